// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: captures a multiplexed 4-digit 7-segment scan into BCD minutes/seconds.
// Illegal-pattern flagging on err_o is built only when SEG_DECODE_ERR_EN is defined.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] seg_bus_i,
    input  logic        clr_err_i,
    output logic [7:0]  min_o,
    output logic [7:0]  sec_o,
    output logic [3:0]  blank_o,
    output logic        frame_valid_o,
    output logic        timeout_o,
    output logic        err_o
);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [TCW-1:0] TIMEOUT_MAX = TCW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

    // Result is {legal, blank, nibble}; input segments are active-low {a..g}.
    function automatic logic [5:0] seg_decode(input logic [6:0] seg_n);
        logic [5:0] res;
        case (~seg_n)
            7'b1111110: res = {2'b10, 4'h0};
            7'b0110000: res = {2'b10, 4'h1};
            7'b1101101: res = {2'b10, 4'h2};
            7'b1111001: res = {2'b10, 4'h3};
            7'b0110011: res = {2'b10, 4'h4};
            7'b1011011: res = {2'b10, 4'h5};
            7'b1011111: res = {2'b10, 4'h6};
            7'b1110000: res = {2'b10, 4'h7};
            7'b1111111: res = {2'b10, 4'h8};
            7'b1111011: res = {2'b10, 4'h9};
            7'b0000000: res = {2'b11, 4'hF};
            default:    res = {2'b00, 4'h0};
        endcase
        return res;
    endfunction

    function automatic logic [1:0] anode_idx(input logic [3:0] an_n);
        logic [1:0] idx;
        case (an_n)
            4'b0111: idx = 2'd3;
            4'b1011: idx = 2'd2;
            4'b1101: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [10:0]          sync1_q, sync2_q, snap_q;
    state_t               state_q;
    logic [SCW-1:0]       cnt_q;
    logic [3:0][3:0]      stage_q;
    logic [3:0]           stage_blank_q, mask_q, mask_d;
    logic [7:0]           min_q, sec_q;
    logic [3:0]           blank_q;
    logic                 frame_valid_q, timeout_q;
    logic [TCW-1:0]       tmo_cnt_q;

    logic [3:0] anode_s;
    logic       one_low_s, same_s, settle_done_s, capture_s, frame_done_s;
    logic [5:0] dec_s;
    logic [1:0] idx_s;

    assign anode_s       = sync2_q[10:7];
    assign one_low_s     = (anode_s == 4'b0111) || (anode_s == 4'b1011) ||
                           (anode_s == 4'b1101) || (anode_s == 4'b1110);
    assign same_s        = (sync2_q == snap_q);
    assign dec_s         = seg_decode(snap_q[6:0]);
    assign idx_s         = anode_idx(snap_q[10:7]);
    assign settle_done_s = (state_q == SETTLE) && same_s && (cnt_q >= SETTLE_LAST);
    assign capture_s     = settle_done_s && dec_s[5];
    assign frame_done_s  = (mask_q == 4'hF);
    assign mask_d        = (frame_done_s ? 4'h0 : mask_q) | (capture_s ? (4'b0001 << idx_s) : 4'h0);

    // Two-flop synchronizer for the asynchronous display bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 11'h7FF;
            sync2_q <= 11'h7FF;
        end else begin
            sync1_q <= seg_bus_i;
            sync2_q <= sync1_q;
        end
    end

    // Scan FSM: wait for one active anode, require a stable run, then hold until the anode moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= 11'h7FF;
            cnt_q   <= {SCW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (one_low_s) begin
                        state_q <= SETTLE;
                        snap_q  <= sync2_q;
                        cnt_q   <= SCW'(1);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SETTLE: begin
                    if (!same_s) begin
                        snap_q  <= sync2_q;
                        cnt_q   <= SCW'(1);
                        state_q <= one_low_s ? SETTLE : IDLE;
                    end else if (cnt_q >= SETTLE_LAST) begin
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + SCW'(1);
                    end
                end
                HOLD: begin
                    if (anode_s != snap_q[10:7]) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Staging of captured digits; mask completion publishes the frame one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q       <= 16'h0000;
            stage_blank_q <= 4'h0;
            mask_q        <= 4'h0;
            min_q         <= 8'h00;
            sec_q         <= 8'h00;
            blank_q       <= 4'h0;
            frame_valid_q <= 1'b0;
        end else begin
            if (capture_s) begin
                stage_q[idx_s]       <= dec_s[3:0];
                stage_blank_q[idx_s] <= dec_s[4];
            end
            mask_q        <= mask_d;
            frame_valid_q <= frame_done_s;
            if (frame_done_s) begin
                min_q   <= {stage_q[3], stage_q[2]};
                sec_q   <= {stage_q[1], stage_q[0]};
                blank_q <= stage_blank_q;
            end
        end
    end

    // Saturating frame-timeout counter, restarted by every completed frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= {TCW{1'b0}};
            timeout_q <= 1'b0;
        end else if (frame_done_s) begin
            tmo_cnt_q <= {TCW{1'b0}};
            timeout_q <= 1'b0;
        end else if (tmo_cnt_q != TIMEOUT_MAX) begin
            tmo_cnt_q <= tmo_cnt_q + TCW'(1);
            timeout_q <= ((tmo_cnt_q + TCW'(1)) == TIMEOUT_MAX);
        end else begin
            timeout_q <= 1'b1;
        end
    end

`ifdef SEG_DECODE_ERR_EN
    logic multi_low_s, illegal_s, err_q;
    assign multi_low_s = !one_low_s && (anode_s != 4'hF);
    assign illegal_s   = ((state_q != HOLD) && multi_low_s) || (settle_done_s && !dec_s[5]);

    // Sticky error flag; a new illegal event outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (illegal_s) begin
            err_q <= 1'b1;
        end else if (clr_err_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q;
        end
    end
    assign err_o = err_q;
`else
    logic unused_clr_s;
    assign unused_clr_s = clr_err_i;
    assign err_o        = 1'b0;
`endif

    assign min_o         = min_q;
    assign sec_o         = sec_q;
    assign blank_o       = blank_q;
    assign frame_valid_o = frame_valid_q;
    assign timeout_o     = timeout_q;
endmodule
